// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, rule tags and
// the grouped hold/flush control bundle.
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

    // Which priority rule produced this cycle's controls; drives the counters.
    typedef enum logic [2:0] {
        RULE_NONE     = 3'd0,
        RULE_MEM      = 3'd1,
        RULE_MC_HOLD  = 3'd2,
        RULE_MC_DONE  = 3'd3,
        RULE_MC_START = 3'd4,
        RULE_BRANCH   = 3'd5,
        RULE_LU       = 3'd6
    } rule_e;

    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic idex_hold;
        logic exmem_hold;
        logic memwb_hold;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } bubble_ctrl_t;

    localparam bubble_ctrl_t CTRL_NONE = 9'b0_0000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Combinational load-use comparator: EX load whose rd feeds a source the ID
// instruction actually reads.
module lu_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_have_inst,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              hazard
);

    assign hazard = ex_mem_read & (ex_rd != {REG_AW{1'b0}}) & id_have_inst &
                    ((id_rs1_used & (id_rs1 == ex_rd)) |
                     (id_rs2_used & (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline.
// Performance counters are built only when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_have_inst,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              ex_mc_valid,
    input  logic              mc_done,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              mc_start,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_hold,
    output logic              exmem_hold,
    output logic              memwb_hold,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic [CNT_W-1:0]  lu_cnt,
    output logic [CNT_W-1:0]  mc_cnt,
    output logic [CNT_W-1:0]  mem_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_e       state_q, state_d;
    logic         done_seen_q, done_seen_d;
    logic         lu_hazard;
    logic         mc_start_s;
    bubble_ctrl_t ctrl_s;
    rule_e        rule_s;

    lu_detect #(.REG_AW(REG_AW)) u_lu_detect (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_have_inst (id_have_inst),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .hazard       (lu_hazard)
    );

    // State and pending-done flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_seen_q <= done_seen_d;
        end
    end

    // Priority rules: first matching condition sets controls and next state.
    always_comb begin
        ctrl_s      = CTRL_NONE;
        rule_s      = RULE_NONE;
        mc_start_s  = 1'b0;
        state_d     = state_q;
        done_seen_d = done_seen_q;
        if (mem_req & ~mem_ready) begin
            rule_s             = RULE_MEM;
            ctrl_s.pc_hold     = 1'b1;
            ctrl_s.ifid_hold   = 1'b1;
            ctrl_s.idex_hold   = 1'b1;
            ctrl_s.exmem_hold  = 1'b1;
            ctrl_s.memwb_flush = 1'b1;
            // A done pulse hidden behind the memory stall must not be lost.
            if ((state_q == MC_WAIT) & mc_done) begin
                done_seen_d = 1'b1;
            end else begin
                done_seen_d = done_seen_q;
            end
        end else if (state_q == MC_WAIT) begin
            if (~(mc_done | done_seen_q)) begin
                rule_s             = RULE_MC_HOLD;
                ctrl_s.pc_hold     = 1'b1;
                ctrl_s.ifid_hold   = 1'b1;
                ctrl_s.idex_hold   = 1'b1;
                ctrl_s.exmem_flush = 1'b1;
            end else begin
                rule_s      = RULE_MC_DONE;
                state_d     = RUN;
                done_seen_d = 1'b0;
            end
        end else if (ex_mc_valid) begin
            rule_s             = RULE_MC_START;
            mc_start_s         = 1'b1;
            ctrl_s.pc_hold     = 1'b1;
            ctrl_s.ifid_hold   = 1'b1;
            ctrl_s.idex_hold   = 1'b1;
            ctrl_s.exmem_flush = 1'b1;
            state_d            = MC_WAIT;
        end else if (ex_branch_taken) begin
            rule_s            = RULE_BRANCH;
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
        end else if (lu_hazard) begin
            rule_s            = RULE_LU;
            ctrl_s.pc_hold    = 1'b1;
            ctrl_s.ifid_hold  = 1'b1;
            ctrl_s.idex_flush = 1'b1;
        end else begin
            rule_s = RULE_NONE;
        end
    end

    // Output gating: everything low in reset, flush overrides hold.
    always_comb begin
        mc_start    = ~rst & mc_start_s;
        pc_hold     = ~rst & ctrl_s.pc_hold;
        ifid_hold   = ~rst & ctrl_s.ifid_hold  & ~ctrl_s.ifid_flush;
        idex_hold   = ~rst & ctrl_s.idex_hold  & ~ctrl_s.idex_flush;
        exmem_hold  = ~rst & ctrl_s.exmem_hold & ~ctrl_s.exmem_flush;
        memwb_hold  = ~rst & ctrl_s.memwb_hold & ~ctrl_s.memwb_flush;
        ifid_flush  = ~rst & ctrl_s.ifid_flush;
        idex_flush  = ~rst & ctrl_s.idex_flush;
        exmem_flush = ~rst & ctrl_s.exmem_flush;
        memwb_flush = ~rst & ctrl_s.memwb_flush;
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en & ~(&v)) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    // Saturating per-rule cycle counters.
    always_comb begin
        lu_cnt_d    = sat_inc(lu_cnt_q,    rule_s == RULE_LU);
        mc_cnt_d    = sat_inc(mc_cnt_q,    (rule_s == RULE_MC_HOLD) | (rule_s == RULE_MC_START));
        mem_cnt_d   = sat_inc(mem_cnt_q,   rule_s == RULE_MEM);
        flush_cnt_d = sat_inc(flush_cnt_q, rule_s == RULE_BRANCH);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q    <= {CNT_W{1'b0}};
            mc_cnt_q    <= {CNT_W{1'b0}};
            mem_cnt_q   <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            lu_cnt_q    <= lu_cnt_d;
            mc_cnt_q    <= mc_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign lu_cnt    = rst ? {CNT_W{1'b0}} : lu_cnt_q;
    assign mc_cnt    = rst ? {CNT_W{1'b0}} : mc_cnt_q;
    assign mem_cnt   = rst ? {CNT_W{1'b0}} : mem_cnt_q;
    assign flush_cnt = rst ? {CNT_W{1'b0}} : flush_cnt_q;
`else
    assign lu_cnt    = {CNT_W{1'b0}};
    assign mc_cnt    = {CNT_W{1'b0}};
    assign mem_cnt   = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; counter expectations follow
// PIPE_HAZARD_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // Control vector order: mc_start, pc/ifid/idex/exmem/memwb hold, ifid/idex/exmem/memwb flush
    localparam logic [9:0] C_NONE = 10'b00_0000_0000;
    localparam logic [9:0] C_LU   = 10'b01_1000_0100;
    localparam logic [9:0] C_BR   = 10'b00_0000_1100;
    localparam logic [9:0] C_MEM  = 10'b01_1110_0001;
    localparam logic [9:0] C_MCH  = 10'b01_1100_0010;
    localparam logic [9:0] C_MCS  = 10'b11_1100_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, id_have_inst;
    logic        ex_mem_read, ex_branch_taken, ex_mc_valid, mc_done, mem_req, mem_ready;
    logic        mc_start, pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [31:0] lu_cnt, mc_cnt, mem_cnt, flush_cnt;
    logic [9:0]  ctl;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctl = {mc_start, pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush};

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_have_inst(id_have_inst),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mc_valid(ex_mc_valid), .mc_done(mc_done), .mem_req(mem_req), .mem_ready(mem_ready),
        .mc_start(mc_start), .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
        .exmem_hold(exmem_hold), .memwb_hold(memwb_hold),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .lu_cnt(lu_cnt), .mc_cnt(mc_cnt), .mem_cnt(mem_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [31:0] expc(input int n);
        return PERF_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_have_inst = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mc_valid = 1'b0;
        mc_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // lw x5 in EX, add x6,x5,x1 in ID
    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_have_inst = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        id_rs2 = 5'd1; id_rs2_used = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        set_load_use();
        ex_mc_valid = 1'b1;
        #2;
        checks++;
        if (ctl !== C_NONE) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE); end
        checks++;
        if ({lu_cnt, mc_cnt, mem_cnt, flush_cnt} !== 128'd0) begin
            failures++; $display("FAIL reset_cnt got=%h exp=0", {lu_cnt, mc_cnt, mem_cnt, flush_cnt});
        end
        cyc();
        rst = 1'b0;
        idle();
        #2;
        checks++;
        if (ctl !== C_NONE) begin failures++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_NONE); end
        checks++;
        if ({lu_cnt, mc_cnt, mem_cnt, flush_cnt} !== 128'd0) begin
            failures++; $display("FAIL post_reset_cnt got=%h exp=0", {lu_cnt, mc_cnt, mem_cnt, flush_cnt});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #2;
        checks++;
        if (ctl !== C_LU) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU); end
        cyc();
        // The bubble is now in EX; the add stays in ID.
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        #2;
        checks++;
        if (ctl !== C_NONE) begin failures++; $display("FAIL lu_release got=%b exp=%b", ctl, C_NONE); end
        checks++;
        if (lu_cnt !== expc(1)) begin failures++; $display("FAIL lu_cnt1 got=%0d exp=%0d", lu_cnt, expc(1)); end
        cyc();
        set_load_use();
        ex_rd = 5'd0; id_rs1 = 5'd0;
        #2;
        checks++;
        if (ctl !== C_NONE) begin failures++; $display("FAIL lu_rd0 got=%b exp=%b", ctl, C_NONE); end
        cyc();
        set_load_use();
        id_rs1 = 5'd3; id_rs2 = 5'd5;
        #2;
        checks++;
        if (ctl !== C_LU) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); end
        cyc();
        id_rs2_used = 1'b0;
        #2;
        checks++;
        if (ctl !== C_NONE) begin failures++; $display("FAIL lu_unused got=%b exp=%b", ctl, C_NONE); end
        cyc();
        checks++;
        if (lu_cnt !== expc(2)) begin failures++; $display("FAIL lu_cnt2 got=%0d exp=%0d", lu_cnt, expc(2)); end
    endtask

    task automatic test_branch();
        do_reset();
        set_load_use();
        ex_branch_taken = 1'b1;
        #2;
        checks++;
        if (ctl !== C_BR) begin failures++; $display("FAIL branch_over_lu got=%b exp=%b", ctl, C_BR); end
        cyc();
        idle();
        #2;
        checks++;
        if (flush_cnt !== expc(1) || lu_cnt !== expc(0)) begin
            failures++; $display("FAIL branch_cnt flush=%0d lu=%0d exp flush=%0d lu=0", flush_cnt, lu_cnt, expc(1));
        end
    endtask

    task automatic test_multicycle();
        int starts;
        int holds;
        logic [9:0] exp_ctl;
        do_reset();
        starts = 0;
        holds = 0;
        ex_mc_valid = 1'b1;
        // Start pulse in cycle 0, done arrives in cycle 5.
        for (int i = 0; i <= 5; i++) begin
            mc_done = (i == 5) ? 1'b1 : 1'b0;
            #2;
            exp_ctl = (i == 0) ? C_MCS : ((i == 5) ? C_NONE : C_MCH);
            checks++;
            if (ctl !== exp_ctl) begin failures++; $display("FAIL mc_cycle%0d got=%b exp=%b", i, ctl, exp_ctl); end
            if (mc_start) starts++;
            if (pc_hold) holds++;
            cyc();
        end
        ex_mc_valid = 1'b0; mc_done = 1'b0;
        #2;
        checks++;
        if (starts != 1 || holds != 5) begin
            failures++; $display("FAIL mc_shape starts=%0d holds=%0d exp starts=1 holds=5", starts, holds);
        end
        checks++;
        if (mc_cnt !== expc(5)) begin failures++; $display("FAIL mc_cnt got=%0d exp=%0d", mc_cnt, expc(5)); end
        cyc();
        // Back in RUN: a new op launches at once, leaving the FSM in MC_WAIT.
        ex_mc_valid = 1'b1;
        #2;
        checks++;
        if (ctl !== C_MCS) begin failures++; $display("FAIL mc_restart got=%b exp=%b", ctl, C_MCS); end
        cyc();
    endtask

    task automatic test_reset_mc_wait();
        rst = 1'b1;
        #2;
        checks++;
        if (ctl !== C_NONE || mc_cnt !== 32'd0) begin
            failures++; $display("FAIL rst_in_mcwait ctl=%b mc_cnt=%0d exp ctl=0 cnt=0", ctl, mc_cnt);
        end
        cyc();
        rst = 1'b0;
        idle();
        #2;
        checks++;
        if (ctl !== C_NONE || mc_cnt !== 32'd0) begin
            failures++; $display("FAIL after_rst_mcwait ctl=%b mc_cnt=%0d exp ctl=0 cnt=0", ctl, mc_cnt);
        end
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== C_BR) begin failures++; $display("FAIL after_rst_run got=%b exp=%b", ctl, C_BR); end
        cyc();
        idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (ctl !== C_MEM) begin failures++; $display("FAIL mem_wait%0d got=%b exp=%b", i, ctl, C_MEM); end
            cyc();
        end
        mem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== C_BR) begin failures++; $display("FAIL mem_branch_release got=%b exp=%b", ctl, C_BR); end
        cyc();
        idle();
        #2;
        checks++;
        if (mem_cnt !== expc(3) || flush_cnt !== expc(1)) begin
            failures++; $display("FAIL mem_cnt mem=%0d flush=%0d exp mem=%0d flush=%0d", mem_cnt, flush_cnt, expc(3), expc(1));
        end
    endtask

    task automatic test_overlap();
        do_reset();
        ex_mc_valid = 1'b1;
        #2;
        checks++;
        if (ctl !== C_MCS) begin failures++; $display("FAIL ovl_start got=%b exp=%b", ctl, C_MCS); end
        cyc();
        mem_req = 1'b1; mem_ready = 1'b0; mc_done = 1'b1;
        #2;
        checks++;
        if (ctl !== C_MEM) begin failures++; $display("FAIL ovl_wait_done got=%b exp=%b", ctl, C_MEM); end
        cyc();
        mc_done = 1'b0;
        #2;
        checks++;
        if (ctl !== C_MEM) begin failures++; $display("FAIL ovl_wait got=%b exp=%b", ctl, C_MEM); end
        cyc();
        mem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== C_NONE) begin failures++; $display("FAIL ovl_release got=%b exp=%b", ctl, C_NONE); end
        cyc();
        mem_req = 1'b0; mem_ready = 1'b0;
        // Next op must wait for its own done: the latched flag was consumed.
        #2;
        checks++;
        if (ctl !== C_MCS) begin failures++; $display("FAIL ovl_next_start got=%b exp=%b", ctl, C_MCS); end
        cyc();
        #2;
        checks++;
        if (ctl !== C_MCH) begin failures++; $display("FAIL ovl_next_hold got=%b exp=%b", ctl, C_MCH); end
        cyc();
        checks++;
        if (mc_cnt !== expc(3) || mem_cnt !== expc(2)) begin
            failures++; $display("FAIL ovl_cnt mc=%0d mem=%0d exp mc=%0d mem=%0d", mc_cnt, mem_cnt, expc(3), expc(2));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_load_use();
        #2;
        checks++;
        if (ctl !== C_LU) begin failures++; $display("FAIL b2b_lu1 got=%b exp=%b", ctl, C_LU); end
        cyc();
        idle();
        ex_branch_taken = 1'b1;
        #2;
        checks++;
        if (ctl !== C_BR) begin failures++; $display("FAIL b2b_br got=%b exp=%b", ctl, C_BR); end
        cyc();
        idle();
        set_load_use();
        id_rs1_used = 1'b0; id_rs2 = 5'd5;
        #2;
        checks++;
        if (ctl !== C_LU) begin failures++; $display("FAIL b2b_lu2 got=%b exp=%b", ctl, C_LU); end
        cyc();
        idle();
        #2;
        checks++;
        if (lu_cnt !== expc(2) || flush_cnt !== expc(1)) begin
            failures++; $display("FAIL b2b_cnt lu=%0d flush=%0d exp lu=%0d flush=%0d", lu_cnt, flush_cnt, expc(2), expc(1));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_multicycle();
        test_reset_mc_wait();
        test_mem_wait();
        test_overlap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
